// File: rtl/controle_rampa_pwm.sv
// Width sequencer for a PWM generator: steps a 2-bit width code through fixed, ramp-up,
// ramp-down or continuous triangle sequences, dwelling CICLOS_PASSO cycles per step.
module controle_rampa_pwm #(
    parameter int unsigned CICLOS_PASSO = 1250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [1:0] modo,
    input  logic [1:0] alvo,
    output logic [1:0] largura,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ESPERA  = 3'd2,
        AVANCA  = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [1:0]  MODO_FIXO     = 2'b00;
    localparam logic [1:0]  MODO_SOBE     = 2'b01;
    localparam logic [1:0]  MODO_DESCE    = 2'b10;
    localparam logic [1:0]  MODO_TRIANGLE = 2'b11;
    localparam logic [31:0] ULTIMO        = 32'(CICLOS_PASSO - 1);

    estado_t     estado_q, estado_d;
    logic [1:0]  largura_q, largura_d;
    logic [31:0] contador_q, contador_d;
    logic        dir_sobe_q, dir_sobe_d;
    logic [1:0]  modo_q, modo_d;
    logic [1:0]  alvo_q, alvo_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            largura_q  <= 2'b00;
            contador_q <= 32'd0;
            dir_sobe_q <= 1'b1;
            modo_q     <= 2'b00;
            alvo_q     <= 2'b00;
        end else begin
            estado_q   <= estado_d;
            largura_q  <= largura_d;
            contador_q <= contador_d;
            dir_sobe_q <= dir_sobe_d;
            modo_q     <= modo_d;
            alvo_q     <= alvo_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        largura_d  = largura_q;
        contador_d = contador_q;
        dir_sobe_d = dir_sobe_q;
        modo_d     = modo_q;
        alvo_d     = alvo_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    modo_d   = modo;
                    alvo_d   = alvo;
                    estado_d = CARREGA;
                end
            end
            CARREGA: begin
                contador_d = 32'd0;
                estado_d   = ESPERA;
                case (modo_q)
                    MODO_FIXO:  largura_d = alvo_q;
                    MODO_SOBE:  largura_d = 2'b00;
                    MODO_DESCE: largura_d = 2'b11;
                    default: begin
                        largura_d  = 2'b00;
                        dir_sobe_d = 1'b1;
                    end
                endcase
            end
            ESPERA: begin
                if (contador_q == ULTIMO) begin
                    contador_d = 32'd0;
                    estado_d   = (modo_q == MODO_FIXO) ? FIM : AVANCA;
                end else begin
                    contador_d = contador_q + 32'd1;
                end
            end
            AVANCA: begin
                estado_d = ESPERA;
                case (modo_q)
                    MODO_SOBE: begin
                        if (largura_q == 2'b11) estado_d = FIM;
                        else                    largura_d = largura_q + 2'b01;
                    end
                    MODO_DESCE: begin
                        if (largura_q == 2'b00) estado_d = FIM;
                        else                    largura_d = largura_q - 2'b01;
                    end
                    MODO_TRIANGLE: begin
                        // Reverse at the ends rather than saturate, so the wave never flattens.
                        if (dir_sobe_q && largura_q == 2'b11) begin
                            dir_sobe_d = 1'b0;
                            largura_d  = 2'b10;
                        end else if (!dir_sobe_q && largura_q == 2'b00) begin
                            dir_sobe_d = 1'b1;
                            largura_d  = 2'b01;
                        end else if (dir_sobe_q) begin
                            largura_d = largura_q + 2'b01;
                        end else begin
                            largura_d = largura_q - 2'b01;
                        end
                    end
                    default: estado_d = FIM;
                endcase
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        // Abort wins over every step or end transition of the running sequence.
        if (parar && (estado_q == CARREGA || estado_q == ESPERA || estado_q == AVANCA)) begin
            largura_d  = 2'b00;
            contador_d = 32'd0;
            estado_d   = FIM;
        end
    end

    assign largura   = largura_q;
    assign ocupado   = (estado_q == CARREGA) || (estado_q == ESPERA) || (estado_q == AVANCA);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_rampa_pwm.sv
// Directed bench for controle_rampa_pwm with a 4-cycle dwell per width step.
module tb_controle_rampa_pwm;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [1:0] modo;
    logic [1:0] alvo;
    logic [1:0] largura;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    int erros  = 0;
    int checks = 0;

    controle_rampa_pwm #(.CICLOS_PASSO(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .modo      (modo),
        .alvo      (alvo),
        .largura   (largura),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One width step: 4 cycles in ESPERA then 1 in AVANCA, width constant throughout.
    task automatic passo(input string tag, input logic [1:0] w);
        for (int k = 0; k < 5; k++) begin
            tick();
            verifica({tag, "_largura"}, 32'(largura), 32'(w));
            verifica({tag, "_estado"}, 32'(db_estado), (k < 4) ? 32'd2 : 32'd3);
        end
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0; modo = 2'b00; alvo = 2'b00;
        tick(); tick();
        verifica("rst_estado", 32'(db_estado), 32'd0);
        verifica("rst_largura", 32'(largura), 32'd0);
        verifica("rst_ocupado", 32'(ocupado), 32'd0);
        verifica("rst_pronto", 32'(pronto), 32'd0);

        // Ramp up, with iniciar and a modo change injected mid-sequence
        reset = 1'b1; modo = 2'b01; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        verifica("up_carrega", 32'(db_estado), 32'd1);
        verifica("up_ocupado", 32'(ocupado), 32'd1);
        passo("up0", 2'd0);
        iniciar = 1'b1; modo = 2'b10;
        passo("up1", 2'd1);
        iniciar = 1'b0;
        passo("up2", 2'd2);
        passo("up3", 2'd3);
        tick();
        verifica("up_fim_estado", 32'(db_estado), 32'd4);
        verifica("up_fim_pronto", 32'(pronto), 32'd1);
        verifica("up_fim_largura", 32'(largura), 32'd3);
        verifica("up_fim_ocupado", 32'(ocupado), 32'd0);
        tick();
        verifica("up_ocioso", 32'(db_estado), 32'd0);
        verifica("up_pronto_pulso", 32'(pronto), 32'd0);
        verifica("up_largura_mantem", 32'(largura), 32'd3);

        // parar while idle does nothing
        parar = 1'b1;
        tick(); tick();
        parar = 1'b0;
        verifica("parar_ocioso_estado", 32'(db_estado), 32'd0);
        verifica("parar_ocioso_pronto", 32'(pronto), 32'd0);
        verifica("parar_ocioso_largura", 32'(largura), 32'd3);

        // Ramp down
        modo = 2'b10; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        verifica("down_carrega", 32'(db_estado), 32'd1);
        passo("down3", 2'd3);
        passo("down2", 2'd2);
        passo("down1", 2'd1);
        passo("down0", 2'd0);
        tick();
        verifica("down_fim_pronto", 32'(pronto), 32'd1);
        verifica("down_fim_largura", 32'(largura), 32'd0);
        tick();
        verifica("down_ocioso", 32'(db_estado), 32'd0);
        verifica("down_sem_wrap", 32'(largura), 32'd0);

        // Fixed width; alvo changed after start must not matter
        modo = 2'b00; alvo = 2'b10; iniciar = 1'b1;
        tick();
        iniciar = 1'b0; alvo = 2'b01;
        verifica("fixo_carrega", 32'(db_estado), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            verifica("fixo_largura", 32'(largura), 32'd2);
            verifica("fixo_espera", 32'(db_estado), 32'd2);
        end
        tick();
        verifica("fixo_fim", 32'(db_estado), 32'd4);
        verifica("fixo_pronto", 32'(pronto), 32'd1);
        verifica("fixo_largura_fim", 32'(largura), 32'd2);
        tick();
        verifica("fixo_ocioso_largura", 32'(largura), 32'd2);

        // Triangle, aborted in ESPERA at width 10
        modo = 2'b11; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        passo("tri0", 2'd0);
        passo("tri1", 2'd1);
        passo("tri2", 2'd2);
        passo("tri3", 2'd3);
        passo("tri2b", 2'd2);
        passo("tri1b", 2'd1);
        passo("tri0b", 2'd0);
        passo("tri1c", 2'd1);
        tick();
        verifica("tri_largura_10", 32'(largura), 32'd2);
        verifica("tri_espera", 32'(db_estado), 32'd2);
        parar = 1'b1;
        tick();
        parar = 1'b0;
        verifica("tri_parar_estado", 32'(db_estado), 32'd4);
        verifica("tri_parar_largura", 32'(largura), 32'd0);
        verifica("tri_parar_pronto", 32'(pronto), 32'd1);
        tick();
        verifica("tri_ocioso", 32'(db_estado), 32'd0);

        // Reset mid-ramp at width 01
        modo = 2'b01; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        passo("rmid0", 2'd0);
        tick();
        verifica("rmid_largura01", 32'(largura), 32'd1);
        reset = 1'b0;
        tick();
        verifica("rmid_estado", 32'(db_estado), 32'd0);
        verifica("rmid_largura", 32'(largura), 32'd0);
        verifica("rmid_ocupado", 32'(ocupado), 32'd0);
        verifica("rmid_pronto", 32'(pronto), 32'd0);
        reset = 1'b1;
        tick();
        verifica("rmid_pos_pronto", 32'(pronto), 32'd0);
        verifica("rmid_pos_estado", 32'(db_estado), 32'd0);

        // iniciar+parar together starts; parar held then aborts in CARREGA
        modo = 2'b00; alvo = 2'b01; iniciar = 1'b1; parar = 1'b1;
        tick();
        iniciar = 1'b0;
        verifica("ambos_carrega", 32'(db_estado), 32'd1);
        tick();
        parar = 1'b0;
        verifica("carrega_parar_estado", 32'(db_estado), 32'd4);
        verifica("carrega_parar_largura", 32'(largura), 32'd0);
        tick();

        // Reset overrides iniciar on the same edge
        reset = 1'b0; iniciar = 1'b1;
        tick();
        verifica("rst_sobre_iniciar", 32'(db_estado), 32'd0);
        reset = 1'b1; iniciar = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
